lut_neuron_table_loader: RTL
============================

// Module: lut_neuron_table_loader
// PURPOSE
//  Writer-side counterpart of the generated fixed-ROM LUT neurons.
//  - Holds a runtime-loadable 2^IN_BITS x OUT_BITS truth table in distributed RAM.
//  - The table is loaded serially, one entry per beat, over a valid/ready stream.
//  - Once loaded, it answers neuron lookups with a registered 1-cycle latency.
//  - Lets a layer's neuron be re-programmed in the field without re-synthesis.
// PARAMETERS
//  IN_BITS   6   lookup address width (neuron fan-in x input bit-width)
//  OUT_BITS  2   entry width (neuron output bit-width)
//  DEPTH     2**IN_BITS   table entries (derived; do not override)
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst        in   1         asynchronous, active-high reset
//  cfg_start  in   1         1-cycle pulse: begin (re)load at entry 0
//  cfg_valid  in   1         config beat valid
//  cfg_ready  out  1         config beat accepted when valid&ready
//  cfg_data   in   OUT_BITS  table entry for current load address
//  cfg_last   in   1         marks final beat of a load
//  load_done  out  1         1-cycle pulse: table loaded successfully
//  load_err   out  1         1-cycle pulse: load aborted (framing error)
//  in_valid   in   1         lookup request
//  in_addr    in   IN_BITS   lookup address (bit0 = M0[0] convention)
//  out_valid  out  1         lookup result valid
//  out_data   out  OUT_BITS  lookup result
// BEHAVIOUR
//  - Reset values: state=IDLE, load counter=0; cfg_ready, load_done, load_err,
//    out_valid and out_data all 0.
//  - Table RAM is not reset. The table is unusable until a load completes.
//  - FSM states: IDLE (no valid table), LOAD, ACTIVE.
//    - IDLE/ACTIVE --cfg_start--> LOAD, counter cleared to 0.
//    - LOAD --accepted beat with counter==DEPTH-1 and cfg_last=1--> ACTIVE;
//      load_done pulses the following cycle.
//    - LOAD --accepted beat with cfg_last=1 and counter<DEPTH-1--> IDLE;
//      load_err pulses (early last).
//    - LOAD --accepted beat with counter==DEPTH-1 and cfg_last=0--> IDLE;
//      load_err pulses (missing last).
//  - cfg_ready = (state==LOAD) && !cfg_start. It is combinational from state and
//    cfg_start only, never from cfg_valid.
//  - Accepted beat: mem[counter] <= cfg_data, then counter increments.
//    Entries arrive in ascending address order, entry 0 first.
//  - A cfg_start during LOAD restarts at entry 0. The beat in that cycle is not
//    accepted, and RAM entries already written stay stale until overwritten.
//  - cfg_valid while not in LOAD is ignored (cfg_ready=0).
//  - Lookup (ACTIVE only): in_valid at cycle t gives out_valid=1 and
//    out_data=mem[in_addr] at t+1. Back-to-back lookups run at 1 per cycle.
//  - in_valid in IDLE/LOAD is dropped: out_valid=0, out_data holds its value.
//  - out_data holds its last value whenever out_valid=0.
//  - Entering LOAD from ACTIVE invalidates the table. A lookup issued in the
//    same cycle as cfg_start is still served (state is still ACTIVE that cycle).
//  - rst mid-load: asynchronous return to IDLE, and a full reload is required.
//  - Counter width is IN_BITS. It never wraps, because the DEPTH-1 beat always
//    leaves LOAD.
// TESTING
//  - Reset, then load mem[a]=a[1:0] (64 beats, last on beat 63) -> load_done
//    one cycle after beat 63; lookup 6'b010011 -> out_data=2'b11 at t+1.
//  - Load with cfg_valid toggling 1-0-1 and cfg_ready sampled -> exactly 64
//    writes; lookups of 0, 63 and 32 back-to-back -> 2'b00, 2'b11, 2'b00.
//  - cfg_last on beat 10 -> load_err pulse, state IDLE; in_valid -> out_valid
//    stays 0.
//  - 64 beats with cfg_last=0 throughout -> load_err after beat 63, no load_done.
//  - Mid-load (beat 20) cfg_start with cfg_valid=1 -> cfg_ready=0 that cycle;
//    a fresh 64-beat load then succeeds with the new data.
//  - rst asserted asynchronously during beat 30 -> all outputs 0 immediately;
//    lookups are ignored until a reload completes.

Source files
------------

// File: rtl/lut_neuron_table_loader.sv
// Runtime-loadable LUT neuron: a serially loaded 2^IN_BITS x OUT_BITS truth table
// in distributed RAM, answering lookups with a registered one-cycle latency.
module lut_neuron_table_loader #(
    parameter int unsigned IN_BITS  = 6,
    parameter int unsigned OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    output logic                load_done,
    output logic                load_err,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_addr,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int unsigned DEPTH = 2 ** IN_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IN_BITS-1:0]    cnt_q, cnt_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0]   out_data_q, out_data_d;
    logic                  mem_we;
    logic [OUT_BITS-1:0]   mem [DEPTH];

    // Combinational by design: depends only on state and cfg_start, never on cfg_valid.
    assign cfg_ready = (state_q == LOAD) && !cfg_start;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        mem_we      = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (cfg_start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else if ((state_q == LOAD) && cfg_valid) begin
            mem_we = 1'b1;
            if (cnt_q == IN_BITS'(DEPTH - 1)) begin
                // Final entry: success only if framed by cfg_last.
                if (cfg_last) begin
                    state_d     = ACTIVE;
                    load_done_d = 1'b1;
                end else begin
                    state_d    = IDLE;
                    load_err_d = 1'b1;
                end
            end else if (cfg_last) begin
                state_d    = IDLE;
                load_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + IN_BITS'(1);
            end
        end

        // Lookups are served on the current state, so one issued alongside cfg_start still completes.
        if (in_valid && (state_q == ACTIVE)) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[in_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Table storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cnt_q] <= cfg_data;
        end
    end

    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
